// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: redirect FSM states and instruction size.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FAULT    = 2'd3
  } redirect_state_e;

  // Byte distance between sequential instructions.
  localparam int INSTR_BYTES = 4;

  // Bubble counter width; holds FLUSH_CYCLES-1 for FLUSH_CYCLES up to 15.
  localparam int FLUSH_CNT_W = 4;

endpackage : cpu_pkg

// File: rtl/branch_target_gen.sv
// Combinational branch target adder with instruction-alignment check.
module branch_target_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_offset,
  output logic [ADDR_WIDTH-1:0] target,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] offset_ext;

  // Fit the offset to the address width: truncate a wide operand, sign-extend a narrow one.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_trunc
      assign offset_ext = br_offset[ADDR_WIDTH-1:0];
    end else begin : g_sext
      assign offset_ext = {{(ADDR_WIDTH-DATA_WIDTH){br_offset[DATA_WIDTH-1]}}, br_offset};
    end
  endgenerate

  // Two's-complement add wraps modulo 2^ADDR_WIDTH, so a negative offset needs no special case.
  assign target     = br_pc + offset_ext;
  assign misaligned = |target[1:0];

endmodule : branch_target_gen

// File: rtl/pc_redirect.sv
// Fetch PC sequencer: sequential fetch, taken-branch redirect with a fixed
// fetch bubble, and a sticky fault on a misaligned branch target.
module pc_redirect
  import cpu_pkg::*;
#(
  parameter int                       ADDR_WIDTH   = 32,
  parameter int                       DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC     = '0,
  parameter int                       FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  br_valid,
  input  logic                  br_taken,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic [DATA_WIDTH-1:0] br_offset,
  output logic                  br_ready,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic                  flush,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr
);

  localparam logic [FLUSH_CNT_W-1:0] BUBBLE_LAST = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0]  PC_STEP     = ADDR_WIDTH'(INSTR_BYTES);

  redirect_state_e        state_q;
  logic [ADDR_WIDTH-1:0]  pc_q;
  logic [FLUSH_CNT_W-1:0] cnt_q;
  logic                   flush_q;
  logic                   fault_q;
  logic [ADDR_WIDTH-1:0]  fault_addr_q;

  logic [ADDR_WIDTH-1:0]  target;
  logic                   misaligned;
  logic                   take_branch;

  branch_target_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_target (
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .target     (target),
    .misaligned (misaligned)
  );

  // Branch outcomes are only accepted while running; br_ready is a pure state decode.
  assign take_branch = (state_q == ST_RUN) && br_valid && br_taken;

  // Redirect FSM: owns the PC, the bubble counter, the flush pulse and the fault record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      // Flush is a single-cycle pulse unless re-armed below.
      flush_q <= 1'b0;
      unique case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (take_branch) begin
            // A taken branch overrides any concurrent fetch handshake; the
            // abandoned request is covered by the flush.
            flush_q <= 1'b1;
            if (misaligned) begin
              fault_q      <= 1'b1;
              fault_addr_q <= target;
              state_q      <= ST_FAULT;
            end else begin
              pc_q    <= target;
              cnt_q   <= BUBBLE_LAST;
              state_q <= ST_REDIRECT;
            end
          end else if (fetch_ready) begin
            pc_q <= pc_q + PC_STEP;
          end
        end
        ST_REDIRECT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RUN;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_FAULT: begin
          state_q <= ST_FAULT;
        end
        default: begin
          state_q <= ST_BOOT;
        end
      endcase
    end
  end

  assign fetch_valid = (state_q == ST_RUN);
  assign br_ready    = (state_q == ST_RUN);
  assign fetch_addr  = pc_q;
  assign flush       = flush_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;

endmodule : pc_redirect

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every PC/address signal.
REQ-002 Parameter DATA_WIDTH, default 32, width of the branch offset operand.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter FLUSH_CYCLES, default 2, fetch bubble length after a redirect; legal range 1..15.
REQ-005 Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- br_valid  input  1  branch outcome valid (driven from comparator branch_valid).
- br_taken  input  1  branch condition result; meaningful only when br_valid=1.
- br_pc  input  ADDR_WIDTH  address of the resolved branch instruction.
- br_offset  input  DATA_WIDTH  sign-extended B-type immediate.
- br_ready  output  1  outcome accepted this cycle when br_valid && br_ready.
- fetch_addr  output  ADDR_WIDTH  instruction fetch address.
- fetch_valid  output  1  fetch request valid.
- fetch_ready  input  1  fetch request accepted when fetch_valid && fetch_ready.
- flush  output  1  one-cycle pulse: discard all wrong-path instructions.
- fault  output  1  sticky misaligned-target fault.
- fault_addr  output  ADDR_WIDTH  offending target address; held while fault=1.

Function
REQ-006 FSM states: BOOT, RUN, REDIRECT, FAULT; encoding is an enum.
REQ-007 BOOT: fetch_valid=0, br_ready=0; unconditional transition to RUN next cycle.
REQ-008 RUN: fetch_valid=1, br_ready=1, fetch_addr=pc register.
REQ-009 RUN, fetch handshake, no taken branch accepted: pc <= pc+4, modulo 2^ADDR_WIDTH (wrap from all-ones-minus-3 to 0).
REQ-010 RUN, br_valid && !br_taken: outcome consumed; no effect on pc, state or flush (predict-not-taken).
REQ-011 Branch target = br_pc + br_offset, offset truncated/sign-extended to ADDR_WIDTH, sum truncated to ADDR_WIDTH.
REQ-012 RUN, br_valid && br_taken with target[1:0]==0: pc <= target, flush=1 next cycle for exactly one cycle, bubble counter <= FLUSH_CYCLES-1, state <= REDIRECT.
REQ-013 RUN, br_valid && br_taken with target[1:0]!=0: fault <= 1, fault_addr <= target, flush=1 one cycle, state <= FAULT.
REQ-014 Simultaneous fetch handshake and accepted taken branch: branch wins; pc <= target, pc+4 discarded.
REQ-015 fetch_addr and fetch_valid stay stable while fetch_valid && !fetch_ready, except when a taken branch is accepted (request abandoned, covered by flush).
REQ-016 REDIRECT: fetch_valid=0, br_ready=0; counter decrements each cycle; at zero, next state RUN with fetch_addr=target.
REQ-017 Total fetch_valid gap from taken-branch acceptance edge to re-assertion = FLUSH_CYCLES cycles.
REQ-018 FAULT: fetch_valid=0, br_ready=0, flush=0; absorbing state, exited only by reset.
REQ-019 All outputs driven from registers or state decode only; no combinational path from br_* or fetch_ready to any output.

Reset
REQ-020 rst_n low asynchronously forces: state=BOOT, pc=RESET_PC, counter=0, flush=0, fault=0, fault_addr=0, hence fetch_valid=0, br_ready=0.
REQ-021 Reset mid-REDIRECT or in FAULT discards pending target and fault; first fetch after release is RESET_PC, issued the second cycle after deassertion.

Structure
REQ-022 Shared package cpu_pkg holds the FSM state enum and constant INSTR_BYTES=4.
REQ-023 Target adder plus alignment check is sub-module branch_target_gen (combinational: br_pc, br_offset -> target, misaligned).

Verification
REQ-024 Reset release, fetch_ready=1: fetch_addr 0x0, 0x4, 0x8 on consecutive cycles, fetch_valid low in BOOT cycle.
REQ-025 br_pc=0x100, br_offset=0xFFFFFFF0, taken: flush one pulse, fetch_valid low 2 cycles, next fetch_addr=0xF0.
REQ-026 Not-taken branch with fetch_ready=0 stall at 0x40: fetch_addr stays 0x40, no flush, br_ready=1.
REQ-027 br_pc=0x200, br_offset=0x6, taken: fault=1, fault_addr=0x206, fetch_valid stays 0 until rst_n pulse, then fetch from RESET_PC.
REQ-028 pc=0xFFFFFFFC handshake -> fetch_addr=0x0; simultaneous fetch handshake and taken branch to 0x80 -> next fetch 0x80 only.
